mcu_channel_buffer: RTL
=======================

MCU_CHANNEL_BUFFER -- requirements
Module: mcu_channel_buffer

Interface
REQ-001 SHALL have parameter W, default 16: signed sample width.
REQ-002 SHALL have parameter NY_MAX, default 4: maximum luma blocks per MCU; the only legal values are 1, 2 and 4.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port mode, input, 2 bits: 0 = 4:4:4 (NY=1), 1 = 4:2:2 (NY=2), 2 = 4:2:0 (NY=4), 3 = illegal.
REQ-006 SHALL have port in_valid, input, 1 bit: an input beat is presented.
REQ-007 SHALL have port in_ready, output, 1 bit: the block can accept a beat.
REQ-008 SHALL have port ch, input, 2 bits: channel tag of the beat; 0 = Y, 1 = Cb, 2 = Cr.
REQ-009 SHALL have port blocks_in, input, signed W x [NY_MAX][8][8]: beat payload; Y uses index 0 only; Cb and Cr use indices 0..NY-1, already upsampled.
REQ-010 SHALL have ports y_out, cb_out and cr_out, output, signed W x [8][8] each: one co-sited block triple.
REQ-011 SHALL have port out_valid, output, 1 bit: the triple on y_out/cb_out/cr_out is valid.
REQ-012 SHALL have port out_ready, input, 1 bit: the downstream stage accepts the triple.
REQ-013 SHALL have port mcu_done, output, 1 bit: one-cycle pulse coincident with the handshake of the last triple of an MCU.
REQ-014 SHALL have port err, output, 1 bit: one-cycle pulse on a protocol violation.

Function
REQ-015 SHALL hold two MCU slots (ping-pong), each storing NY_MAX Y, NY_MAX Cb and NY_MAX Cr blocks.
REQ-016 SHALL assert in_ready = !full[wr_slot]; a beat is accepted only when in_valid && in_ready.
REQ-017 SHALL run a write FSM WR_Y -> WR_CB -> WR_CR -> WR_Y.
- WR_Y: expects ch=0; the k-th accepted Y beat writes Y[k]. After NY beats, go to WR_CB.
- WR_CB: expects ch=1; one beat writes Cb[0..NY-1]; go to WR_CR.
- WR_CR: expects ch=2; one beat writes Cr[0..NY-1], sets full[wr_slot], toggles wr_slot, and goes to WR_Y.
REQ-018 SHALL latch NY per slot from mode on the first Y beat of each MCU and hold it until that slot drains; mode changes mid-MCU SHALL have no effect.
REQ-019 SHALL treat mode=3 as NY=1 and pulse err on the latching beat.
REQ-020 SHALL handle an accepted beat whose ch mismatches the FSM state (including ch=3) as follows: drop it, leave the FSM state, counters and storage unchanged, and pulse err the following cycle.
REQ-021 SHALL assert out_valid = full[rd_slot]; outputs SHALL present Y[idx], Cb[idx], Cr[idx] of rd_slot, and SHALL be all-zero when out_valid=0.
REQ-022 SHALL, on out_valid && out_ready:
- idx < NY-1: increment idx.
- idx = NY-1: clear full[rd_slot], toggle rd_slot, set idx to 0, and assert mcu_done in the same cycle (combinational).
REQ-023 SHALL hold the output triple stable while out_valid=1 and out_ready=0.
REQ-024 SHALL present the first triple of an MCU (out_valid=1) in the cycle after its Cr beat is accepted; latency is 1 cycle.
REQ-025 SHALL sustain simultaneous fill of wr_slot and drain of rd_slot in one cycle without interaction.
REQ-026 SHALL handle a slot freed by a drain in cycle t (both slots full) as follows: in_ready rises in cycle t+1; there is no combinational out_ready-to-in_ready path.
REQ-027 SHALL support full throughput in 4:2:0: 6 input beats per MCU, 4 output triples per MCU, no bubbles when out_ready=1.

Reset
REQ-028 SHALL, while rst=0 (asynchronously): full=2'b00, wr_slot=rd_slot=0, idx=0, Y beat count=0, FSM=WR_Y, in_ready=1, out_valid=0, mcu_done=0, err=0, all outputs 0.
REQ-029 SHALL, on reset assertion mid-MCU or mid-drain, discard all partial and buffered MCUs; block storage need not be cleared.

Verification
REQ-030 SHALL cover 4:2:0 single MCU, out_ready=1: Y beats with 1,2,3,4 in element [0][0], Cb all 10+k, Cr all 20+k.
- Required: the cycle after the Cr beat, 4 consecutive triples with y[0][0]=1..4, cb=10..13, cr=20..23.
- Required: mcu_done is asserted on the 4th triple.
REQ-031 SHALL cover back-to-back 4:4:4 MCUs with out_ready=0.
- Required: in_ready=0 after 6 beats (2 MCUs buffered).
- Required: raising out_ready releases a triple per cycle; in_ready returns to 1 one cycle after the first drain.
REQ-032 SHALL cover a Cb beat sent while in WR_Y in 4:2:2.
- Required: err pulses once; the beat is dropped; the correct sequence that follows produces 2 valid triples.
REQ-033 SHALL cover out_ready toggling 1,0,1 during a 4:2:2 drain.
- Required: the triple is held during the stall; mcu_done asserts exactly once.
REQ-034 SHALL cover rst=0 asserted after 2 of 4 Y beats.
- Required: out_valid=0 immediately, in_ready=1.
- Required: a fresh MCU decodes correctly after rst=1.
REQ-035 SHALL cover mode=3 on the first Y beat.
- Required: err pulses; the MCU completes as 4:4:4 with 1 triple.

Source files
------------

// File: rtl/mcu_channel_buffer_if.sv
// Channel-buffer stream interface.
// Carries the input beat stream (mode, in_valid/in_ready, ch, blocks_in) and
// the output triple stream (y/cb/cr_out, out_valid/out_ready, mcu_done, err).
// master: the environment side (drives beats, accepts triples).
// slave : the buffer side.
interface mcu_channel_buffer_if #(
    parameter int W      = 16,
    parameter int NY_MAX = 4
);
    logic [1:0]          mode;
    logic                in_valid;
    logic                in_ready;
    logic [1:0]          ch;
    logic signed [W-1:0] blocks_in [NY_MAX][8][8];
    logic signed [W-1:0] y_out     [8][8];
    logic signed [W-1:0] cb_out    [8][8];
    logic signed [W-1:0] cr_out    [8][8];
    logic                out_valid;
    logic                out_ready;
    logic                mcu_done;
    logic                err;

    modport master (
        output mode, in_valid, ch, blocks_in, out_ready,
        input  in_ready, y_out, cb_out, cr_out, out_valid, mcu_done, err
    );

    modport slave (
        input  mode, in_valid, ch, blocks_in, out_ready,
        output in_ready, y_out, cb_out, cr_out, out_valid, mcu_done, err
    );
endinterface

// File: rtl/mcu_channel_buffer.sv
// MCU channel buffer: collects one MCU of Y, Cb and Cr blocks per slot in a
// two-slot ping-pong store and replays it as co-sited (Y, Cb, Cr) triples.
// Ports:
//   clk  - single clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - slave side of mcu_channel_buffer_if (input beats, output triples,
//          mcu_done pulse, err pulse)
module mcu_channel_buffer #(
    parameter int W      = 16,
    parameter int NY_MAX = 4
) (
    input logic                  clk,
    input logic                  rst,
    mcu_channel_buffer_if.slave  bus
);
    localparam logic [1:0] NYM1_MAX = 2'(NY_MAX - 1);

    typedef enum logic [1:0] {
        WR_Y  = 2'd0,
        WR_CB = 2'd1,
        WR_CR = 2'd2
    } wr_state_e;

    // Luma blocks per MCU minus one; illegal mode 3 falls back to 4:4:4,
    // and the result is clamped so it never exceeds the built storage.
    function automatic logic [1:0] mode_to_nym1(input logic [1:0] m);
        logic [1:0] n;
        case (m)
            2'd0:    n = 2'd0;
            2'd1:    n = 2'd1;
            2'd2:    n = 2'd3;
            default: n = 2'd0;
        endcase
        if (n > NYM1_MAX) begin
            n = NYM1_MAX;
        end
        return n;
    endfunction

    wr_state_e       state_q, state_d;
    logic [1:0]      full_q, full_d;
    logic            wr_slot_q, wr_slot_d;
    logic            rd_slot_q, rd_slot_d;
    logic [1:0]      idx_q, idx_d;
    logic [1:0]      ycnt_q, ycnt_d;
    logic [1:0][1:0] slot_nym1_q, slot_nym1_d;
    logic            err_q, err_d;

    logic            accept_s, ch_ok_s, beat_ok_s, first_y_s;
    logic [1:0]      beat_nym1_s;
    logic            y_we_s, cb_we_s, cr_we_s;
    logic            out_valid_s, drain_s, last_s;

    logic signed [W-1:0] y_mem_q  [2][NY_MAX][8][8];
    logic signed [W-1:0] cb_mem_q [2][NY_MAX][8][8];
    logic signed [W-1:0] cr_mem_q [2][NY_MAX][8][8];

    // in_ready depends only on registered state, so a drain never reaches it
    // combinationally; the freed slot shows up one cycle later.
    assign accept_s    = bus.in_valid && !full_q[wr_slot_q];
    assign out_valid_s = full_q[rd_slot_q];
    assign drain_s     = out_valid_s && bus.out_ready;
    assign last_s      = drain_s && (idx_q == slot_nym1_q[rd_slot_q]);
    assign first_y_s   = (state_q == WR_Y) && (ycnt_q == 2'd0);

    assign bus.in_ready  = !full_q[wr_slot_q];
    assign bus.out_valid = out_valid_s;
    assign bus.mcu_done  = last_s;
    assign bus.err       = err_q;

    // State register: FSM, slot bookkeeping and counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= WR_Y;
            full_q      <= 2'b00;
            wr_slot_q   <= 1'b0;
            rd_slot_q   <= 1'b0;
            idx_q       <= 2'd0;
            ycnt_q      <= 2'd0;
            slot_nym1_q <= '{2'd0, 2'd0};
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            full_q      <= full_d;
            wr_slot_q   <= wr_slot_d;
            rd_slot_q   <= rd_slot_d;
            idx_q       <= idx_d;
            ycnt_q      <= ycnt_d;
            slot_nym1_q <= slot_nym1_d;
            err_q       <= err_d;
        end
    end

    // Next-state logic of the write FSM; beats with the wrong tag are ignored.
    always_comb begin
        state_d     = state_q;
        beat_nym1_s = first_y_s ? mode_to_nym1(bus.mode) : slot_nym1_q[wr_slot_q];
        case (state_q)
            WR_Y:    ch_ok_s = (bus.ch == 2'd0);
            WR_CB:   ch_ok_s = (bus.ch == 2'd1);
            WR_CR:   ch_ok_s = (bus.ch == 2'd2);
            default: ch_ok_s = 1'b0;
        endcase
        beat_ok_s = accept_s && ch_ok_s;
        if (beat_ok_s) begin
            case (state_q)
                WR_Y: begin
                    if (ycnt_q == beat_nym1_s) begin
                        state_d = WR_CB;
                    end else begin
                        state_d = WR_Y;
                    end
                end
                WR_CB:   state_d = WR_CR;
                WR_CR:   state_d = WR_Y;
                default: state_d = WR_Y;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // FSM outputs and datapath control: write enables, counters, slot flags.
    always_comb begin
        y_we_s      = beat_ok_s && (state_q == WR_Y);
        cb_we_s     = beat_ok_s && (state_q == WR_CB);
        cr_we_s     = beat_ok_s && (state_q == WR_CR);
        ycnt_d      = ycnt_q;
        slot_nym1_d = slot_nym1_q;
        wr_slot_d   = wr_slot_q;
        rd_slot_d   = rd_slot_q;
        idx_d       = idx_q;
        full_d      = full_q;
        // Mismatched tags (incl. 3) and mode 3 on the latching beat both flag err.
        err_d = (accept_s && !ch_ok_s) || (y_we_s && first_y_s && (bus.mode == 2'd3));

        if (y_we_s) begin
            if (ycnt_q == beat_nym1_s) begin
                ycnt_d = 2'd0;
            end else begin
                ycnt_d = ycnt_q + 2'd1;
            end
            if (first_y_s) begin
                slot_nym1_d[wr_slot_q] = beat_nym1_s;
            end else begin
                slot_nym1_d = slot_nym1_q;
            end
        end else begin
            ycnt_d = ycnt_q;
        end

        // Write side sets full on a slot that is empty, read side clears a
        // full one, so the two never touch the same bit in one cycle.
        if (cr_we_s) begin
            full_d[wr_slot_q] = 1'b1;
            wr_slot_d         = !wr_slot_q;
        end else begin
            wr_slot_d = wr_slot_q;
        end

        if (last_s) begin
            full_d[rd_slot_q] = 1'b0;
            rd_slot_d         = !rd_slot_q;
            idx_d             = 2'd0;
        end else if (drain_s) begin
            idx_d = idx_q + 2'd1;
        end else begin
            idx_d = idx_q;
        end
    end

    // Block storage; contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (y_we_s) begin
            y_mem_q[wr_slot_q][ycnt_q] <= bus.blocks_in[0];
        end
        if (cb_we_s) begin
            cb_mem_q[wr_slot_q] <= bus.blocks_in;
        end
        if (cr_we_s) begin
            cr_mem_q[wr_slot_q] <= bus.blocks_in;
        end
    end

    // Output triple of the read slot, forced to zero when nothing is valid.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                if (out_valid_s) begin
                    bus.y_out[i][j]  = y_mem_q[rd_slot_q][idx_q][i][j];
                    bus.cb_out[i][j] = cb_mem_q[rd_slot_q][idx_q][i][j];
                    bus.cr_out[i][j] = cr_mem_q[rd_slot_q][idx_q][i][j];
                end else begin
                    bus.y_out[i][j]  = {W{1'b0}};
                    bus.cb_out[i][j] = {W{1'b0}};
                    bus.cr_out[i][j] = {W{1'b0}};
                end
            end
        end
    end
endmodule
